// File: rtl/lcd_cmd_arbiter.sv
// Two-requester arbiter in front of the LCD controller handshake.
// Round-robin per burst; each word is start, wait-done, then settle.
module lcd_cmd_arbiter #(
   parameter int DLY_W     = 18,
   parameter int SHORT_DLY = 63166,
   parameter int LONG_DLY  = 200000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       req0_valid,
   input  logic [8:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [8:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic       ctrl_Start,
   output logic       ctrl_RS,
   output logic [7:0] ctrl_DATA,
   input  logic       ctrl_Done,
   output logic       owner,
   output logic       locked,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DELAY
   } state_t;

   localparam logic [DLY_W-1:0] SHORT_M1 = DLY_W'(SHORT_DLY - 1);
   localparam logic [DLY_W-1:0] LONG_M1  = DLY_W'(LONG_DLY - 1);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             locked_q, locked_d;
   logic             prio_q, prio_d;
   logic             last_q, last_d;
   logic             long_q, long_d;
   logic             start_q, start_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic [DLY_W-1:0] dly_q, dly_d;

   logic       rdy0, rdy1;
   logic [8:0] word;
   logic       wlast;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         locked_q <= 1'b0;
         prio_q   <= 1'b0;
         last_q   <= 1'b0;
         long_q   <= 1'b0;
         start_q  <= 1'b0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
         dly_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         locked_q <= locked_d;
         prio_q   <= prio_d;
         last_q   <= last_d;
         long_q   <= long_d;
         start_q  <= start_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         dly_q    <= dly_d;
      end
   end

   // Grant: locked owner only, else the single valid one, else the pointer.
   always_comb begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      if (iRST_N && state_q == S_IDLE) begin
         if (locked_q) begin
            rdy0 = !owner_q && req0_valid;
            rdy1 = owner_q && req1_valid;
         end else if (req0_valid && req1_valid) begin
            rdy0 = !prio_q;
            rdy1 = prio_q;
         end else begin
            rdy0 = req0_valid;
            rdy1 = req1_valid;
         end
      end
   end

   assign word  = rdy1 ? req1_data : req0_data;
   assign wlast = rdy1 ? req1_last : req0_last;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      locked_d = locked_q;
      prio_d   = prio_q;
      last_d   = last_q;
      long_d   = long_q;
      start_d  = start_q;
      rs_d     = rs_q;
      data_d   = data_q;
      dly_d    = dly_q;
      unique case (state_q)
         S_IDLE: begin
            if (rdy0 || rdy1) begin
               rs_d     = word[8];
               data_d   = word[7:0];
               last_d   = wlast;
               long_d   = !word[8] && (word[7:2] == 6'd0)
                          && (word[1:0] != 2'd0);
               owner_d  = rdy1;
               locked_d = 1'b1;
               start_d  = 1'b1;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ctrl_Done) begin
               start_d = 1'b0;
               dly_d   = '0;
               state_d = S_DELAY;
            end
         end
         S_DELAY: begin
            dly_d = dly_q + DLY_W'(1);
            if (dly_q == (long_q ? LONG_M1 : SHORT_M1)) begin
               state_d = S_IDLE;
               if (last_q) begin
                  locked_d = 1'b0;
                  prio_d   = !owner_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req0_ready = rdy0;
   assign req1_ready = rdy1;
   assign ctrl_Start = start_q;
   assign ctrl_RS    = rs_q;
   assign ctrl_DATA  = data_q;
   assign owner      = owner_q;
   assign locked     = locked_q;
   assign busy       = (state_q != S_IDLE) || locked_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Bench for lcd_cmd_arbiter: directed plan steps plus random bursts,
// checked against a transaction-level model of grant and timing rules.
module tb_lcd_cmd_arbiter;

   localparam int SD = 4;
   localparam int LD = 10;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [8:0] req0_data = '0, req1_data = '0;
   logic       req0_last = 1'b0, req1_last = 1'b0;
   logic       req0_ready, req1_ready;
   logic       ctrl_Start, ctrl_RS, ctrl_Done;
   logic [7:0] ctrl_DATA;
   logic       owner, locked, busy;
   logic       force_done = 1'b0;
   logic [1:0] ccnt = '0;

   lcd_cmd_arbiter #(
      .DLY_W(18), .SHORT_DLY(SD), .LONG_DLY(LD)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .req0_valid(req0_valid), .req0_data(req0_data),
      .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data),
      .req1_last(req1_last), .req1_ready(req1_ready),
      .ctrl_Start(ctrl_Start), .ctrl_RS(ctrl_RS),
      .ctrl_DATA(ctrl_DATA), .ctrl_Done(ctrl_Done),
      .owner(owner), .locked(locked), .busy(busy)
   );

   always #5 iCLK = ~iCLK;

   // Controller model: Done on the third cycle Start is high.
   always @(posedge iCLK) ccnt <= ctrl_Start ? ccnt + 2'd1 : 2'd0;
   assign ctrl_Done = (ctrl_Start && ccnt == 2'd2) || force_done;

   int checks = 0;
   int errors = 0;

   logic [9:0] q0[$];
   logic [9:0] q1[$];
   bit rnd = 0;
   bit rst_edge = 0;
   bit hs0, hs1;

   int   m_phase = 0;
   bit   m_lock = 0, m_owner = 0, m_pref = 0, m_long = 0;
   logic [9:0] m_w = '0;
   int   xcnt = 0, scnt = 0;
   bit   e0, e1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task drive();
      bit g0, g1;
      g0 = rnd && ($urandom_range(0, 3) == 0);
      g1 = rnd && ($urandom_range(0, 3) == 0);
      req0_valid = (q0.size() > 0) && !g0;
      req1_valid = (q1.size() > 0) && !g1;
      if (q0.size() > 0) {req0_last, req0_data} = q0[0];
      if (q1.size() > 0) {req1_last, req1_data} = q1[0];
   endtask

   task model_check();
      if (!rst_edge) begin
         m_phase = 0; m_lock = 0; m_owner = 0; m_pref = 0;
         chk("rst_start", ctrl_Start, 0);
         chk("rst_locked", locked, 0);
         chk("rst_owner", owner, 0);
         chk("rst_busy", busy, 0);
      end
      if (!iRST_N) begin
         chk("rst_rdy0", req0_ready, 0);
         chk("rst_rdy1", req1_ready, 0);
         return;
      end
      e0 = 0; e1 = 0;
      if (m_phase == 0) begin
         if (m_lock) begin
            e0 = req0_valid && !m_owner;
            e1 = req1_valid && m_owner;
         end else if (req0_valid && req1_valid) begin
            e0 = !m_pref;
            e1 = m_pref;
         end else begin
            e0 = req0_valid;
            e1 = req1_valid;
         end
      end
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("locked", locked, m_lock);
      chk("owner", owner, m_owner);
      chk("busy", busy, (m_phase != 0) || m_lock);
      case (m_phase)
         0: begin
            chk("idle_start", ctrl_Start, 0);
            if (e0 || e1) begin
               m_w = e1 ? {req1_last, req1_data} : {req0_last, req0_data};
               m_owner = e1;
               m_lock = 1;
               m_long = (m_w[8] == 0) && (m_w[7:0] >= 1) && (m_w[7:0] <= 3);
               m_phase = 1;
               xcnt = 0;
            end
         end
         1: begin
            chk("xfer_start", ctrl_Start, 1);
            chk("xfer_rs", ctrl_RS, m_w[8]);
            chk("xfer_data", ctrl_DATA, m_w[7:0]);
            xcnt++;
            if (xcnt == 3) begin
               m_phase = 2;
               scnt = 0;
            end
         end
         default: begin
            chk("settle_start", ctrl_Start, 0);
            scnt++;
            if (scnt == (m_long ? LD : SD)) begin
               m_phase = 0;
               if (m_w[9]) begin
                  m_lock = 0;
                  m_pref = !m_owner;
               end
            end
         end
      endcase
   endtask

   task cycle();
      @(negedge iCLK);
      model_check();
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge iCLK);
      rst_edge = iRST_N;
      #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      drive();
   endtask

   task run_until(input int maxc);
      int n;
      bit ok;
      n = 0;
      drive();
      do begin
         cycle();
         n++;
      end while (!(q0.size() == 0 && q1.size() == 0 && m_phase == 0)
                 && n < maxc);
      ok = (q0.size() == 0 && q1.size() == 0 && m_phase == 0);
      chk("drain", ok, 1);
   endtask

   task do_reset();
      iRST_N = 1'b0;
      cycle();
      iRST_N = 1'b1;
   endtask

   initial begin
      int n, len;
      bit ok;
      repeat (3) cycle();
      iRST_N = 1'b1;
      cycle();

      q0.push_back(10'h341);
      run_until(50);
      chk("pref_after_single", m_pref, 1);

      do_reset();
      q0.push_back(10'h3AA);
      q1.push_back(10'h3BB);
      run_until(80);

      q0.push_back(10'h080);
      q0.push_back(10'h148);
      q0.push_back(10'h369);
      q1.push_back(10'h377);
      run_until(150);

      q1.push_back(10'h001);
      q1.push_back(10'h038);
      q1.push_back(10'h302);
      run_until(150);

      q0.push_back(10'h0C0);
      q1.push_back(10'h3EE);
      drive();
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(q0.size() == 0 && m_phase == 0) && n < 60);
      ok = (q0.size() == 0 && m_phase == 0);
      chk("hold_reach", ok, 1);
      repeat (20) cycle();
      chk("hold_locked", locked, 1);
      chk("hold_rdy1", req1_ready, 0);
      q0.push_back(10'h3DD);
      run_until(150);

      q0.push_back(10'h355);
      drive();
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(m_phase == 1 && xcnt == 1) && n < 20);
      chk("mid_wait_reach", m_phase, 1);
      chk("mid_wait_start", ctrl_Start, 1);
      do_reset();
      cycle();
      force_done = 1'b1;
      cycle();
      force_done = 1'b0;
      repeat (3) cycle();
      chk("stray_done_start", ctrl_Start, 0);
      chk("stray_done_busy", busy, 0);

      rnd = 1;
      for (int b = 0; b < 30; b++) begin
         len = $urandom_range(1, 3);
         for (int k = 0; k < len; k++)
            q0.push_back({(k == len - 1) ? 1'b1 : 1'b0,
                          9'($urandom_range(0, 511))});
         len = $urandom_range(1, 3);
         for (int k = 0; k < len; k++)
            q1.push_back({(k == len - 1) ? 1'b1 : 1'b0,
                          9'($urandom_range(0, 511))});
      end
      run_until(8000);
      rnd = 0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
